fight_logic: RTL

Game-rules stage directly downstream of the camera gesture detector. It consumes the per-player punch and kick levels and detects their rising edges. It applies damage with per-player cooldowns, tracks both health bars and runs the round state machine (idle, fight, win or draw). Its outputs feed the health-bar renderer and the hit flash and sound effects.

---
 rtl/fight_logic.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fight_logic.sv
// Round rules for a two-player gesture fighting game: detects attack edges, applies
// damage under per-player cooldowns, tracks both health bars and the round state.
module fight_logic #(
  parameter int MAX_HEALTH      = 100,
  parameter int PUNCH_DMG       = 5,
  parameter int KICK_DMG        = 10,
  parameter int COOLDOWN_CYCLES = 32_500_000
) (
  input  logic       clk_65mhz,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_punch,
  input  logic       p1_kick,
  input  logic       p2_punch,
  input  logic       p2_kick,
  output logic [6:0] p1_health,
  output logic [6:0] p2_health,
  output logic [2:0] game_state,
  output logic       p1_hit,
  output logic       p2_hit,
  output logic       p1_ready,
  output logic       p2_ready
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FIGHT  = 3'd1,
    P1_WIN = 3'd2,
    P2_WIN = 3'd3,
    DRAW   = 3'd4
  } state_t;

  localparam logic [6:0]  MAX_H = 7'(MAX_HEALTH);
  localparam logic [6:0]  P_DMG = 7'(PUNCH_DMG);
  localparam logic [6:0]  K_DMG = 7'(KICK_DMG);
  localparam logic [24:0] CD    = 25'(COOLDOWN_CYCLES);

  state_t      state;
  logic [3:0]  act_p0, act_p1, rise;
  logic [24:0] cd1, cd2;
  logic [6:0]  p1_dmg, p2_dmg;
  logic        p1_fire, p2_fire;

  function automatic logic [6:0] sat_sub(input logic [6:0] h, input logic [6:0] d);
    return (h <= d) ? 7'd0 : h - d;
  endfunction

  // Stage p0/p1: sample and history of the action levels, {p2_kick,p2_punch,p1_kick,p1_punch}
  always_ff @(posedge clk_65mhz or posedge reset) begin
    if (reset) begin
      act_p0 <= '0;
      act_p1 <= '0;
    end else begin
      act_p0 <= {p2_kick, p2_punch, p1_kick, p1_punch};
      act_p1 <= act_p0;
    end
  end

  assign rise = act_p0 & ~act_p1;

  // A simultaneous kick and punch edge counts only as the kick.
  always_comb begin
    p1_dmg  = rise[1] ? K_DMG : (rise[0] ? P_DMG : 7'd0);
    p2_dmg  = rise[3] ? K_DMG : (rise[2] ? P_DMG : 7'd0);
    p1_fire = (state == FIGHT) && (cd1 == '0) && (rise[1:0] != 2'b00);
    p2_fire = (state == FIGHT) && (cd2 == '0) && (rise[3:2] != 2'b00);
  end

  assign game_state = state;
  assign p1_ready   = (cd1 == '0);
  assign p2_ready   = (cd2 == '0);

  // Stage p2: health, cooldown, hit pulses and round state
  always_ff @(posedge clk_65mhz or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      p1_health <= MAX_H;
      p2_health <= MAX_H;
      cd1       <= '0;
      cd2       <= '0;
      p1_hit    <= 1'b0;
      p2_hit    <= 1'b0;
    end else begin
      p1_hit <= 1'b0;
      p2_hit <= 1'b0;
      case (state)
        IDLE: begin
          p1_health <= MAX_H;
          p2_health <= MAX_H;
          cd1       <= '0;
          cd2       <= '0;
          if (start) state <= FIGHT;
        end
        FIGHT: begin
          if (p1_health == 7'd0 || p2_health == 7'd0) begin
            if (p1_health == 7'd0 && p2_health == 7'd0) state <= DRAW;
            else if (p2_health == 7'd0)                 state <= P1_WIN;
            else                                         state <= P2_WIN;
            cd1 <= '0;
            cd2 <= '0;
          end else begin
            // Both sides resolve against the pre-update health values.
            if (p1_fire) begin
              p2_health <= sat_sub(p2_health, p1_dmg);
              cd1       <= CD;
              p1_hit    <= 1'b1;
            end else if (cd1 != '0) begin
              cd1 <= cd1 - 25'd1;
            end
            if (p2_fire) begin
              p1_health <= sat_sub(p1_health, p2_dmg);
              cd2       <= CD;
              p2_hit    <= 1'b1;
            end else if (cd2 != '0) begin
              cd2 <= cd2 - 25'd1;
            end
          end
        end
        P1_WIN, P2_WIN, DRAW: begin
          cd1 <= '0;
          cd2 <= '0;
          if (start) begin
            state     <= FIGHT;
            p1_health <= MAX_H;
            p2_health <= MAX_H;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
